// File: rtl/frac_mult_pkg.sv
// Shared types and widths for the fractioned 32x32 multiplier.
// Holds the FSM state enum, the step counter type and the operand magnitude helper.
package frac_mult_pkg;

    localparam int OPERAND_W = 32;
    localparam int FRAC_W    = 16;
    localparam int PRODUCT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    // -2^31 maps to 0x8000_0000, which still fits the unsigned magnitude.
    function automatic logic [OPERAND_W-1:0] magnitude(input logic [OPERAND_W-1:0] v,
                                                        input logic              is_signed);
        logic [OPERAND_W-1:0] m;
        m = (is_signed && v[OPERAND_W-1]) ? (~v + 1'b1) : v;
        return m;
    endfunction

endpackage

// File: rtl/mul16x16_unsigned.sv
// Combinational 16x16 -> 32 unsigned multiplier; the single array shared by every step.
// Zero latency, no flow control.
module mul16x16_unsigned
    import frac_mult_pkg::*;
(
    input  logic [FRAC_W-1:0]   op_a_i,
    input  logic [FRAC_W-1:0]   op_b_i,
    output logic [2*FRAC_W-1:0] prod_o
);

    always_comb begin
        prod_o = op_a_i * op_b_i;
    end

endmodule

// File: rtl/fractioned_multiplier.sv
// Signed/unsigned 32x32 -> 64 multiplier, one 16x16 partial product per cycle; a result every 6 cycles.
// No backpressure: output_valid pulses once per result. `FRAC_MULT_BUSY_EN adds the busy output.
module fractioned_multiplier
    import frac_mult_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [OPERAND_W-1:0] input_a,
    input  logic [OPERAND_W-1:0] input_b,
    input  logic                 signed_a,
    input  logic                 signed_b,
    input  logic                 enable,
    output logic [OPERAND_W-1:0] output_lower,
    output logic [OPERAND_W-1:0] output_higher,
    output logic                 output_valid
`ifdef FRAC_MULT_BUSY_EN
    ,
    output logic                 busy
`endif
);

    state_t                 state_q, state_d;
    step_t                  step_q, step_d;
    logic [OPERAND_W-1:0]   mag_a_q, mag_a_d;
    logic [OPERAND_W-1:0]   mag_b_q, mag_b_d;
    logic                   sign_q, sign_d;
    logic [PRODUCT_W-1:0]   acc_q, acc_d;
    logic [OPERAND_W-1:0]   lower_q, lower_d;
    logic [OPERAND_W-1:0]   higher_q, higher_d;
    logic                   valid_q, valid_d;

    logic [FRAC_W-1:0]      pp_a, pp_b;
    logic [2*FRAC_W-1:0]    pp;
    logic [PRODUCT_W-1:0]   pp_shifted;
    logic [PRODUCT_W-1:0]   result;

    // Operand halves selected per step: LL, LH, HL, HH.
    always_comb begin
        pp_a = mag_a_q[FRAC_W-1:0];
        pp_b = mag_b_q[FRAC_W-1:0];
        case (step_q)
            2'd0: begin
                pp_a = mag_a_q[FRAC_W-1:0];
                pp_b = mag_b_q[FRAC_W-1:0];
            end
            2'd1: begin
                pp_a = mag_a_q[FRAC_W-1:0];
                pp_b = mag_b_q[OPERAND_W-1:FRAC_W];
            end
            2'd2: begin
                pp_a = mag_a_q[OPERAND_W-1:FRAC_W];
                pp_b = mag_b_q[FRAC_W-1:0];
            end
            default: begin
                pp_a = mag_a_q[OPERAND_W-1:FRAC_W];
                pp_b = mag_b_q[OPERAND_W-1:FRAC_W];
            end
        endcase
    end

    mul16x16_unsigned u_mul (
        .op_a_i (pp_a),
        .op_b_i (pp_b),
        .prod_o (pp)
    );

    always_comb begin
        pp_shifted = {{(PRODUCT_W-2*FRAC_W){1'b0}}, pp};
        case (step_q)
            2'd0:    pp_shifted = {{(PRODUCT_W-2*FRAC_W){1'b0}}, pp};
            2'd1,
            2'd2:    pp_shifted = {{(PRODUCT_W-2*FRAC_W){1'b0}}, pp} << FRAC_W;
            default: pp_shifted = {{(PRODUCT_W-2*FRAC_W){1'b0}}, pp} << (2*FRAC_W);
        endcase
    end

    assign result = sign_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        lower_d  = lower_q;
        higher_d = higher_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    mag_a_d = magnitude(input_a, signed_a);
                    mag_b_d = magnitude(input_b, signed_b);
                    sign_d  = (signed_a & input_a[OPERAND_W-1]) ^ (signed_b & input_b[OPERAND_W-1]);
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                lower_d  = result[OPERAND_W-1:0];
                higher_d = result[PRODUCT_W-1:OPERAND_W];
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            step_q   <= 2'd0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            lower_q  <= '0;
            higher_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            lower_q  <= lower_d;
            higher_q <= higher_d;
            valid_q  <= valid_d;
        end
    end

    assign output_lower  = lower_q;
    assign output_higher = higher_q;
    assign output_valid  = valid_q;

`ifdef FRAC_MULT_BUSY_EN
    assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_fractioned_multiplier.sv
// Directed and randomized checks of fractioned_multiplier against a 64-bit arithmetic reference.
module tb_fractioned_multiplier;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] input_a, input_b;
    logic        signed_a, signed_b, enable;
    logic [31:0] output_lower, output_higher;
    logic        output_valid;
`ifdef FRAC_MULT_BUSY_EN
    logic        busy;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fractioned_multiplier dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .input_a       (input_a),
        .input_b       (input_b),
        .signed_a      (signed_a),
        .signed_b      (signed_b),
        .enable        (enable),
        .output_lower  (output_lower),
        .output_higher (output_higher),
        .output_valid  (output_valid)
`ifdef FRAC_MULT_BUSY_EN
        ,
        .busy          (busy)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits per its flag and multiply modulo 2^64.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'h8000_0000;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One operation with enable dropped and inputs scrambled right after capture.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input string tag);
        logic [63:0] exp;
        int          lat;
        @(negedge clock);
        input_a = a; input_b = b; signed_a = sa; signed_b = sb; enable = 1'b1;
        @(posedge clock); #1;
        exp = ref_prod(a, b, sa, sb);
`ifdef FRAC_MULT_BUSY_EN
        check({tag, " busy"}, {63'd0, busy}, 64'd1);
`endif
        @(negedge clock);
        enable = 1'b0;
        input_a = $urandom; input_b = $urandom;
        signed_a = 1'($urandom); signed_b = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clock); #1;
            if (output_valid) lat = i;
        end
        check({tag, " latency"}, 64'(lat), 64'd5);
        check({tag, " product"}, {output_higher, output_lower}, exp);
        @(posedge clock); #1;
        check({tag, " valid drop"}, {63'd0, output_valid}, 64'd0);
        check({tag, " hold"}, {output_higher, output_lower}, exp);
`ifdef FRAC_MULT_BUSY_EN
        check({tag, " idle"}, {63'd0, busy}, 64'd0);
`endif
    endtask

    initial begin
        int vcount;
        reset_n = 1'b0; enable = 1'b0;
        input_a = '0; input_b = '0; signed_a = 1'b0; signed_b = 1'b0;
        #12;
        check("reset lower", {32'd0, output_lower}, 64'd0);
        check("reset higher", {32'd0, output_higher}, 64'd0);
        check("reset valid", {63'd0, output_valid}, 64'd0);
        @(negedge clock); reset_n = 1'b1;

        // Held enable: first pulse 5 edges after capture, then every 6.
        @(negedge clock);
        input_a = 32'd69; input_b = 32'd127; signed_a = 1'b0; signed_b = 1'b0; enable = 1'b1;
        @(posedge clock); #1;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clock); #1;
            check("stream valid", {63'd0, output_valid}, (i % 6 == 5) ? 64'd1 : 64'd0);
            if (i % 6 == 5)
                check("stream product", {output_higher, output_lower}, 64'h0000_0000_0000_223B);
        end
        @(negedge clock); enable = 1'b0;
        repeat (8) @(posedge clock);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "full unsigned");
        check("full unsigned const", {output_higher, output_lower}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "min signed");
        check("min signed const", {output_higher, output_lower}, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "mixed");
        check("mixed const", {output_higher, output_lower}, 64'hFFFF_FFFF_0000_0001);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, "pre reset");

        // Reset while step counter is at 2.
        @(negedge clock);
        input_a = 32'h0001_0003; input_b = 32'h0002_0005; signed_a = 1'b0; signed_b = 1'b0; enable = 1'b1;
        @(posedge clock); #1;
        @(negedge clock); enable = 1'b0;
        @(posedge clock); @(posedge clock); #2;
        reset_n = 1'b0; #1;
        check("abort lower", {32'd0, output_lower}, 64'd0);
        check("abort higher", {32'd0, output_higher}, 64'd0);
        check("abort valid", {63'd0, output_valid}, 64'd0);
        @(negedge clock); reset_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (output_valid) vcount++;
        end
        check("abort no valid", 64'(vcount), 64'd0);
        run_op(32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0, "after reset");

        for (int k = 0; k < 24; k++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
